// File: rtl/shift_arbiter.sv
// ============================================================================
// Module   : shift_arbiter
// Brief    : Round-robin shared barrel shifter serving two requesters.
//            Optional statistics counters enabled by SHIFT_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] str0,
    input  logic [AMT_W-1:0] amt0,
    input  logic             left0,
    output logic             gnt0,
    output logic             valid0,
    input  logic             req1,
    input  logic [WIDTH-1:0] str1,
    input  logic [AMT_W-1:0] amt1,
    input  logic             left1,
    output logic             gnt1,
    output logic             valid1,
`ifdef SHIFT_ARB_STATS_EN
    output logic [15:0]      op_count,
    output logic [15:0]      conflict_count,
`endif
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    logic [0:0]       r_state;
    logic             r_ptr;        // 1 = favour port 1 on contention
    logic             r_owner;
    logic [WIDTH-1:0] r_op_str;
    logic [AMT_W-1:0] r_op_amt;
    logic             r_op_left;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_valid0;
    logic             r_valid1;
    logic [WIDTH-1:0] r_result;

    logic             w_any_req;
    logic             w_pick1;
    logic [WIDTH-1:0] w_shift;

    assign w_any_req = req0 | req1;
    // Port 1 wins if it is the only requester, or both request and it is favoured.
    assign w_pick1   = req1 & (~req0 | r_ptr);

    always_comb begin
        w_shift = '0;
        if (r_op_left) begin
            w_shift = r_op_str << r_op_amt;
        end else begin
            w_shift = WIDTH'($signed(r_op_str) >>> r_op_amt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_owner   <= 1'b0;
            r_op_str  <= '0;
            r_op_amt  <= '0;
            r_op_left <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_valid0  <= 1'b0;
            r_valid1  <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid0 <= 1'b0;
                    r_valid1 <= 1'b0;
                    if (w_any_req) begin
                        r_op_str  <= w_pick1 ? str1  : str0;
                        r_op_amt  <= w_pick1 ? amt1  : amt0;
                        r_op_left <= w_pick1 ? left1 : left0;
                        r_gnt0    <= ~w_pick1;
                        r_gnt1    <= w_pick1;
                        r_owner   <= w_pick1;
                        r_ptr     <= ~w_pick1;
                        r_state   <= S_EXEC;
                    end else begin
                        r_gnt0 <= 1'b0;
                        r_gnt1 <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_result <= w_shift;
                    r_valid0 <= ~r_owner;
                    r_valid1 <= r_owner;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign valid0 = r_valid0;
    assign valid1 = r_valid1;
    assign result = r_result;
    assign busy   = (r_state == S_EXEC);

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] r_op_count;
    logic [15:0] r_conflict_count;

    // Counted on the edge that launches the valid pulse, so the count lines up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count       <= '0;
            r_conflict_count <= '0;
        end else begin
            if ((r_state == S_EXEC) && (r_op_count != 16'hFFFF)) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if ((r_state == S_IDLE) && req0 && req1 && (r_conflict_count != 16'hFFFF)) begin
                r_conflict_count <= r_conflict_count + 16'd1;
            end
        end
    end

    assign op_count       = r_op_count;
    assign conflict_count = r_conflict_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Directed vector bench for shift_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, left0, req1, left1;
    logic [15:0] str0, str1;
    logic [3:0]  amt0, amt1;
    logic        gnt0, valid0, gnt1, valid1, busy;
    logic [15:0] result;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] op_count, conflict_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .str0(str0), .amt0(amt0), .left0(left0),
        .gnt0(gnt0), .valid0(valid0),
        .req1(req1), .str1(str1), .amt1(amt1), .left1(left1),
        .gnt1(gnt1), .valid1(valid1),
`ifdef SHIFT_ARB_STATS_EN
        .op_count(op_count), .conflict_count(conflict_count),
`endif
        .result(result), .busy(busy)
    );

    typedef struct {
        logic        port;
        logic [15:0] str;
        logic [3:0]  amt;
        logic        left;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h8000, 4'd4,  1'b0, 16'hF800};
        vecs[1] = '{1'b1, 16'h0001, 4'd15, 1'b1, 16'h8000};
        vecs[2] = '{1'b1, 16'h7FF0, 4'd4,  1'b0, 16'h07FF};
        vecs[3] = '{1'b0, 16'hA5A5, 4'd0,  1'b1, 16'hA5A5};
        vecs[4] = '{1'b0, 16'hA5A5, 4'd0,  1'b0, 16'hA5A5};
        vecs[5] = '{1'b0, 16'h8001, 4'd15, 1'b0, 16'hFFFF};
        vecs[6] = '{1'b1, 16'h1234, 4'd4,  1'b1, 16'h2340};
        vecs[7] = '{1'b0, 16'hF0F0, 4'd8,  1'b1, 16'hF000};
        vecs[8] = '{1'b1, 16'h4000, 4'd14, 1'b0, 16'h0001};

        req0 = 0; req1 = 0; str0 = 0; str1 = 0; amt0 = 0; amt1 = 0; left0 = 0; left1 = 0;
        @(negedge clk);
        do_reset();

        chk("reset_gnt0", 32'(gnt0), 32'd0);
        chk("reset_gnt1", 32'(gnt1), 32'd0);
        chk("reset_valid", 32'({valid0, valid1}), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Solo requests from the vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].port) begin
                req1 = 1; str1 = vecs[i].str; amt1 = vecs[i].amt; left1 = vecs[i].left;
            end else begin
                req0 = 1; str0 = vecs[i].str; amt0 = vecs[i].amt; left0 = vecs[i].left;
            end
            tick();
            chk($sformatf("v%0d_gnt", i), 32'({gnt1, gnt0}), vecs[i].port ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            chk($sformatf("v%0d_novalid", i), 32'({valid1, valid0}), 32'd0);
            req0 = 0; req1 = 0;
            tick();
            chk($sformatf("v%0d_valid", i), 32'({valid1, valid0}), vecs[i].port ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp));
            chk($sformatf("v%0d_gnt_clr", i), 32'({gnt1, gnt0, busy}), 32'd0);
            tick();
            chk($sformatf("v%0d_valid_clr", i), 32'({valid1, valid0}), 32'd0);
            chk($sformatf("v%0d_result_hold", i), 32'(result), 32'(vecs[i].exp));
        end

        // Continuous contention: grants alternate starting with port 0
        do_reset();
        req0 = 1; str0 = 16'h0003; amt0 = 4'd1; left0 = 1;
        req1 = 1; str1 = 16'h8000; amt1 = 4'd1; left1 = 0;
        for (int i = 0; i < 8; i++) begin
            int g;
            g = (i / 2) % 2;
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("rr%0d_gnt", i), 32'({gnt1, gnt0}), g ? 32'd2 : 32'd1);
                chk($sformatf("rr%0d_busy", i), 32'(busy), 32'd1);
            end else begin
                chk($sformatf("rr%0d_valid", i), 32'({valid1, valid0}), g ? 32'd2 : 32'd1);
                chk($sformatf("rr%0d_result", i), 32'(result), g ? 32'h0000C000 : 32'h00000006);
                chk($sformatf("rr%0d_gnt_clr", i), 32'({gnt1, gnt0}), 32'd0);
            end
        end
        req0 = 0; req1 = 0;
        tick();

        // Reset during EXEC drops the operation
        req0 = 1; str0 = 16'h00FF; amt0 = 4'd2; left0 = 1;
        tick();
        chk("rx_gnt0", 32'(gnt0), 32'd1);
        req0 = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("rx_valid", 32'({valid1, valid0}), 32'd0);
        chk("rx_result", 32'(result), 32'd0);
        chk("rx_busy", 32'(busy), 32'd0);
        chk("rx_gnt", 32'({gnt1, gnt0}), 32'd0);
        tick();
        chk("rx_late_valid", 32'({valid1, valid0}), 32'd0);
        req0 = 1; req1 = 1;
        tick();
        chk("rx_ptr_reset", 32'({gnt1, gnt0}), 32'd1);
        req0 = 0; req1 = 0;
        tick();
        tick();

        // Reset on the same edge as a request: no grant
        reset = 1; req1 = 1;
        tick();
        chk("rr_same_edge_gnt", 32'({gnt1, gnt0, busy}), 32'd0);
        req1 = 0; reset = 0;
        tick();
        chk("rr_same_edge_idle", 32'({gnt1, gnt0, busy}), 32'd0);

`ifdef SHIFT_ARB_STATS_EN
        do_reset();
        chk("stats_reset", 32'({op_count, conflict_count}), 32'd0);
        for (int p = 0; p < 3; p++) begin
            req0 = 1; req1 = 1;
            tick();
            req0 = 0;
            tick();
            tick();
            req1 = 0;
            tick();
        end
        req0 = 1;
        tick();
        req0 = 0;
        tick();
        tick();
        chk("stats_op_count", 32'(op_count), 32'd7);
        chk("stats_conflict_count", 32'(conflict_count), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
